// File: rtl/storage_pkg.sv
// Shared constants for the FIFO read-side packer: FSM state encoding and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package storage_pkg;

    // Packer FSM states, kept as plain constants so legacy tools can read them.
    localparam logic FILL = 1'b0;   // accumulating words from the FIFO
    localparam logic HOLD = 1'b1;   // accumulator full, waiting for the output register

    // Width of a counter that must hold the values 0..ratio inclusive.
    function automatic int cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Valid/ready holding register for packed words; loads a new word when the packer asks.
// Latency: 1 cycle from load_i to m_valid.
// Backpressure: word held stable while m_valid && !m_ready; reload in a transfer cycle keeps m_valid high.
//
// Ports: clk/rst_n (sync, active-low); load_i/load_data_i (+ load_keep_i) from the packer;
//        m_valid/m_ready/m_data (+ m_keep) toward the next stage.
// Optional: PACKER_FLUSH_EN adds the lane-keep mask path.
module packer_out_reg #(
    parameter int WIDTH = 4,
    parameter int RATIO = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic [WIDTH*RATIO-1:0]   load_data_i,
`ifdef PACKER_FLUSH_EN
    input  logic [RATIO-1:0]         load_keep_i,
    output logic [RATIO-1:0]         m_keep,
`endif
    input  logic                     m_ready,
    output logic                     m_valid,
    output logic [WIDTH*RATIO-1:0]   m_data
);

    logic                   valid_q, valid_d;
    logic [WIDTH*RATIO-1:0] data_q, data_d;
`ifdef PACKER_FLUSH_EN
    logic [RATIO-1:0]       keep_q, keep_d;
`endif

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef PACKER_FLUSH_EN
        keep_d  = keep_q;
`endif
        if (load_i) begin
            // A reload wins over a same-cycle transfer.
            valid_d = 1'b1;
            data_d  = load_data_i;
`ifdef PACKER_FLUSH_EN
            keep_d  = load_keep_i;
`endif
        end else if (m_ready) begin
            // Data is left in place after a transfer; only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef PACKER_FLUSH_EN
            keep_q  <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef PACKER_FLUSH_EN
            keep_q  <= keep_d;
`endif
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
`ifdef PACKER_FLUSH_EN
    assign m_keep  = keep_q;
`endif

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops WIDTH-bit words from a 1-cycle-latency FIFO read port and packs RATIO of them per output word.
// Latency: 1 cycle from the capture of the last lane to m_valid; full rate, no bubbles.
// Backpressure: stops popping once the accumulator would overrun (HOLD) while m_valid && !m_ready.
//
// Ports: clk/rst_n (sync, active-low); fifo_empty/fifo_rd_en/fifo_data toward the FIFO read port;
//        m_valid/m_ready/m_data (+ m_keep) packed stream, first-popped word in the low lane.
// Optional: PACKER_FLUSH_EN emits a zero-padded partial word after FLUSH_CYCLES idle cycles.
module fifo_rd_packer
    import storage_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int RATIO        = 2,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [WIDTH-1:0]         fifo_data,
    output logic                     m_valid,
    input  logic                     m_ready,
`ifdef PACKER_FLUSH_EN
    output logic [RATIO-1:0]         m_keep,
`endif
    output logic [WIDTH*RATIO-1:0]   m_data
);

    localparam int               CNT_W   = cnt_w(RATIO);
    localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        infl_q;
    logic                        state_q, state_d;
    logic [RATIO-1:0][WIDTH-1:0] lanes_q, lanes_d;

    logic                        out_free;
    logic                        load;
    logic [WIDTH*RATIO-1:0]      load_data;
`ifdef PACKER_FLUSH_EN
    logic [RATIO-1:0]            load_keep;
`endif

    assign out_free = !m_valid || m_ready;

    // Words already counted plus the one in flight must fit; the last lane may be
    // refilled in the same cycle it completes only if the output register takes the word.
    always_comb begin
        fifo_rd_en = rst_n && !fifo_empty && (state_q == FILL) &&
                     ((cnt_q + CNT_W'(infl_q)) < RATIO_C ||
                      (infl_q && cnt_q == LAST_C && out_free));
    end

`ifdef PACKER_FLUSH_EN
    localparam int                IDLE_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_cond;
    logic              flush;

    assign idle_cond = (state_q == FILL) && (cnt_q != '0) && !infl_q && fifo_empty;
    // idle_q reaches FLUSH_CYCLES-1 on the FLUSH_CYCLES-th idle cycle; the word loads on that edge.
    assign flush     = idle_cond && (idle_q == IDLE_LAST) && out_free;

    always_comb begin
        idle_d = '0;
        if (idle_cond && !fifo_rd_en && !flush) begin
            idle_d = (idle_q == IDLE_LAST) ? idle_q : idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        lanes_d   = lanes_q;
        load      = 1'b0;
        load_data = lanes_q;
`ifdef PACKER_FLUSH_EN
        load_keep = '1;
`endif
        case (state_q)
            FILL: begin
                if (infl_q) begin
                    if (cnt_q == LAST_C) begin
                        if (out_free) begin
                            // Bypass the last lane straight into the output register.
                            load = 1'b1;
                            load_data[WIDTH*RATIO-1 -: WIDTH] = fifo_data;
                            cnt_d = '0;
                        end else begin
                            lanes_d[RATIO-1] = fifo_data;
                            state_d = HOLD;
                        end
                    end else begin
                        for (int i = 0; i < RATIO; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                lanes_d[i] = fifo_data;
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef PACKER_FLUSH_EN
                else if (flush) begin
                    load = 1'b1;
                    for (int i = 0; i < RATIO; i++) begin
                        load_data[i*WIDTH +: WIDTH] = (CNT_W'(i) < cnt_q) ? lanes_q[i] : '0;
                        load_keep[i]                = (CNT_W'(i) < cnt_q);
                    end
                    cnt_d = '0;
                end
`endif
            end
            default: begin // HOLD
                if (out_free) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            infl_q  <= 1'b0;
            state_q <= FILL;
            lanes_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            infl_q  <= fifo_rd_en;
            state_q <= state_d;
            lanes_q <= lanes_d;
        end
    end

    packer_out_reg #(
        .WIDTH (WIDTH),
        .RATIO (RATIO)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (load_data),
`ifdef PACKER_FLUSH_EN
        .load_keep_i (load_keep),
        .m_keep      (m_keep),
`endif
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_data      (m_data)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (WIDTH=4, RATIO=2) with a behavioural 1-cycle-latency FIFO.
// Latency: n/a.
// Backpressure: driven via m_ready.
module tb_fifo_rd_packer;

    localparam int WIDTH = 4;
    localparam int RATIO = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic [WIDTH-1:0]       fifo_data = '0;
    logic                   m_valid;
    logic                   m_ready;
    logic [WIDTH*RATIO-1:0] m_data;
`ifdef PACKER_FLUSH_EN
    logic [RATIO-1:0]       m_keep;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural FIFO: registered data_out, valid the cycle after a pop.
    logic [WIDTH-1:0] mem [0:63];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic             pop_empty = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                pop_empty <= 1'b1;
            end else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    fifo_rd_packer #(
        .WIDTH        (WIDTH),
        .RATIO        (RATIO),
        .FLUSH_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef PACKER_FLUSH_EN
        .m_keep     (m_keep),
`endif
        .m_data     (m_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] s_rd;
        logic [6:0] s_v;
        logic [7:0] s_d [7];
        logic [7:0] b_rd;
        logic [7:0] b_v;
        bit         seen;

        // ---- Reset: FIFO already holds data, yet no pop while rst_n is low ----
        rst_n   = 1'b0;
        m_ready = 1'b1;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        step();
        step();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'h00);
        chk("rst_rd_en",   32'(fifo_rd_en), 32'd0);
`ifdef PACKER_FLUSH_EN
        chk("rst_m_keep",  32'(m_keep), 32'd0);
`endif

        // ---- Streaming at full rate: 4 consecutive pops, 0x21 then 0x43 ----
        rst_n = 1'b1;
        #1;
        s_rd = 7'b0001111;
        s_v  = 7'b0101000;
        s_d  = '{8'h00, 8'h00, 8'h00, 8'h21, 8'h00, 8'h43, 8'h00};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("stream_rd_en[%0d]", k), 32'(fifo_rd_en), 32'(s_rd[k]));
            chk($sformatf("stream_valid[%0d]", k), 32'(m_valid), 32'(s_v[k]));
            if (s_v[k]) begin
                chk($sformatf("stream_data[%0d]", k), 32'(m_data), 32'(s_d[k]));
`ifdef PACKER_FLUSH_EN
                chk($sformatf("stream_keep[%0d]", k), 32'(m_keep), 32'b11);
`endif
            end
            step();
        end

        // ---- Backpressure: 0x21 held, accumulator fills, pops stop ----
        m_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        #1;
        b_rd = 8'b00001111;
        b_v  = 8'b11111000;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_rd_en[%0d]", k), 32'(fifo_rd_en), 32'(b_rd[k]));
            chk($sformatf("bp_valid[%0d]", k), 32'(m_valid), 32'(b_v[k]));
            if (b_v[k]) begin
                chk($sformatf("bp_data[%0d]", k), 32'(m_data), 32'h21);
            end
            step();
        end
        m_ready = 1'b1;
        step();
        chk("bp_second_valid", 32'(m_valid), 32'd1);
        chk("bp_second_data",  32'(m_data),  32'h43);
        chk("bp_second_rd_en", 32'(fifo_rd_en), 32'd0);
        step();
        chk("bp_drained_valid", 32'(m_valid), 32'd0);

        // ---- FIFO empty mid-word: lane 0 waits for the next push ----
        push(4'h5);
        #1;
        chk("mid_pop5", 32'(fifo_rd_en), 32'd1);
        step();
        chk("mid_no_pop_empty", 32'(fifo_rd_en), 32'd0);
        step();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("mid_wait_valid[%0d]", k), 32'(m_valid), 32'd0);
            step();
        end
        push(4'h6);
        #1;
        chk("mid_pop6", 32'(fifo_rd_en), 32'd1);
        step();
        chk("mid_last_no_pop", 32'(fifo_rd_en), 32'd0);
        step();
        chk("mid_valid", 32'(m_valid), 32'd1);
        chk("mid_data",  32'(m_data),  32'h65);
        step();
        chk("mid_drained", 32'(m_valid), 32'd0);

`ifdef PACKER_FLUSH_EN
        // ---- Flush: lone word 7 emitted 16 cycles after its capture ----
        push(4'h7);
        #1;
        step();
        step();
        for (int k = 2; k < 18; k++) begin
            chk($sformatf("flush_wait_valid[%0d]", k), 32'(m_valid), 32'd0);
            step();
        end
        chk("flush_valid", 32'(m_valid), 32'd1);
        chk("flush_data",  32'(m_data),  32'h07);
        chk("flush_keep",  32'(m_keep),  32'b01);
        step();
        chk("flush_drained", 32'(m_valid), 32'd0);
`endif

        // ---- Reset mid-word: captured 9 is discarded ----
        push(4'h9);
        #1;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rstmid_valid", 32'(m_valid), 32'd0);
        rst_n = 1'b1;
        push(4'hA);
        push(4'hB);
        #1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            if (m_valid) seen = 1'b1;
            else step();
        end
        chk("rstmid_valid_rise", 32'(seen), 32'd1);
        chk("rstmid_data", 32'(m_data), 32'hBA);
        step();
        chk("rstmid_drained", 32'(m_valid), 32'd0);

        chk("fifo_drained", 32'(rd_ptr), 32'(wr_ptr));
        chk("no_pop_when_empty", 32'(pop_empty), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
